// File: rtl/pmci_vdm_rx_reasm.sv
// PMCI VDM receive reassembler: strips MCTP headers, stitches packet payloads into one message buffer
// and serves it through the CSR pop port. Define PMCI_VDM_RX_DROP_CNT_EN to add the FCR[31:16] drop counter.
module pmci_vdm_rx_reasm #(
  parameter int DEPTH      = 256,
  parameter int MAX_PKT_DW = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_err,
  input  logic        csr_rd_pdr,
  output logic [31:0] pdr_rdata,
  output logic        pdr_rvalid,
  input  logic        csr_wr_fcr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] fcr_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(MAX_PKT_DW + 2);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] MAXP_C = PW'(MAX_PKT_DW);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, DROP, READY} state_e;

  state_e        state_q, state_d;
  logic          run_q;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, len_q, len_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    tag_q, tag_d;
  logic [1:0]    seq_q, seq_d;
  logic          eom_q, eom_d;
  logic          seq_err_q, seq_err_d, tlp_err_q, tlp_err_d, ovf_q, ovf_d;
  logic          seq_set, tlp_set, ovf_set, drop_inc, fail_c, mem_we, accept;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic [15:0]   drop_field;
  logic [10:0]   len_ext;
  logic [31:0]   mem [DEPTH];

  // in_ready comes only from registered state, never from in_valid
  assign in_ready = run_q && (state_q != READY);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    len_d    = len_q;
    pcnt_d   = pcnt_q;
    tag_d    = tag_q;
    seq_d    = seq_q;
    eom_d    = eom_q;
    seq_set  = 1'b0;
    tlp_set  = 1'b0;
    ovf_set  = 1'b0;
    drop_inc = 1'b0;
    fail_c   = 1'b0;
    mem_we   = 1'b0;
    rdata_d  = 32'h0;
    rvalid_d = 1'b0;

    if (csr_rd_pdr) begin
      rvalid_d = 1'b1;
      if (state_q == READY) begin
        if (rptr_q < len_q) rdata_d = mem[rptr_q[AW-1:0]];
        rptr_d = rptr_q + 1'b1;
        if (rptr_q + 1'b1 >= len_q) state_d = IDLE;
      end
    end

    if (accept) begin
      if (state_q == DROP) begin
        if (in_eop) state_d = IDLE;
      end else if (in_sop) begin
        pcnt_d = PW'(1);
        if (in_data[31]) begin
          // a fresh SOM mid-message restarts in place, losing the partial message
          if (state_q == ASSEMBLE) begin
            seq_set  = 1'b1;
            drop_inc = 1'b1;
          end
          tag_d   = in_data[26:24];
          seq_d   = in_data[29:28];
          eom_d   = in_data[30];
          wptr_d  = '0;
          state_d = ASSEMBLE;
        end else if (state_q == IDLE) begin
          drop_inc = 1'b1;
          fail_c   = 1'b1;
        end else if ((in_data[29:28] != seq_q + 2'd1) || (in_data[26:24] != tag_q)) begin
          seq_set  = 1'b1;
          drop_inc = 1'b1;
          fail_c   = 1'b1;
        end else begin
          seq_d = in_data[29:28];
          eom_d = in_data[30];
        end
      end else if (state_q == ASSEMBLE) begin
        pcnt_d = pcnt_q + 1'b1;
        if (in_eop && in_err) begin
          mem_we = 1'b0;
        end else if ((pcnt_q >= MAXP_C) || (wptr_q == FULL_C)) begin
          ovf_set  = 1'b1;
          drop_inc = 1'b1;
          fail_c   = 1'b1;
        end else begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
        end
      end

      if (!fail_c && (state_q != DROP) && (state_d == ASSEMBLE) && in_eop) begin
        if (in_err) begin
          tlp_set  = 1'b1;
          drop_inc = 1'b1;
          state_d  = IDLE;
        end else if (eom_d) begin
          state_d = READY;
          len_d   = wptr_d;
          rptr_d  = '0;
        end
      end
      // the error dword may itself be the eop, in which case nothing is left to consume
      if (fail_c) state_d = in_eop ? IDLE : DROP;
    end

    seq_err_d = seq_set | (seq_err_q & ~(csr_wr_fcr & csr_wdata[13]));
    tlp_err_d = tlp_set | (tlp_err_q & ~(csr_wr_fcr & csr_wdata[14]));
    ovf_d     = ovf_set | (ovf_q     & ~(csr_wr_fcr & csr_wdata[15]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      len_q     <= '0;
      pcnt_q    <= '0;
      tag_q     <= '0;
      seq_q     <= '0;
      eom_q     <= 1'b0;
      seq_err_q <= 1'b0;
      tlp_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      len_q     <= len_d;
      pcnt_q    <= pcnt_d;
      tag_q     <= tag_d;
      seq_q     <= seq_d;
      eom_q     <= eom_d;
      seq_err_q <= seq_err_d;
      tlp_err_q <= tlp_err_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[AW-1:0]] <= in_data;
  end

`ifdef PMCI_VDM_RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        unused_wdata;

  // clear first so a drop in the clearing cycle is still counted
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (csr_wr_fcr && csr_wdata[31]) drop_cnt_d = '0;
    if (drop_inc && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_field   = drop_cnt_q;
  assign unused_wdata = ^{csr_wdata[30:16], csr_wdata[12:0], len_ext[10]};
`else
  logic unused_wdata;
  assign drop_field   = '0;
  assign unused_wdata = ^{csr_wdata[31:16], csr_wdata[12:0], len_ext[10], drop_inc};
`endif

  assign len_ext    = 11'(len_q);
  assign fcr_rdata  = {drop_field, ovf_q, tlp_err_q, seq_err_q, (state_q == READY), 2'b00, len_ext[9:0]};
  assign pdr_rdata  = rdata_q;
  assign pdr_rvalid = rvalid_q;

endmodule
